// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package hazard_pkg;

   localparam int FWD_RF = 0;
   // Widest register address the tag entries can hold; narrower REG_AW is zero-extended.
   localparam int TAG_AW = 8;

   typedef struct packed {
      logic              valid;
      logic [TAG_AW-1:0] dst;
      logic              is_load;
   } tag_entry_t;

   function automatic int sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority encoder over the in-flight destination tags.
module fwd_match
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   parameter int SEL_W    = 2
) (
   input  tag_entry_t        tags [DEPTH],
   input  logic [REG_AW-1:0] src,
   input  logic              used,
   output logic [SEL_W-1:0]  sel,
   output logic              load_hit
);

   logic [TAG_AW-1:0] src_ext;

   assign src_ext = TAG_AW'(src);

   // Walk oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      sel      = SEL_W'(FWD_RF);
      load_hit = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (used && tags[k].valid && (tags[k].dst == src_ext)) begin
            sel      = SEL_W'(k + 1);
            load_hit = tags[k].is_load && (k < LOAD_LAT);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select generation and load-use stall detection beside the ID/EX register.
module fwd_hazard_unit
   import hazard_pkg::*;
#(
   parameter  int REG_AW   = 5,
   parameter  int NUM_SRC  = 2,
   parameter  int DEPTH    = 3,
   parameter  int LOAD_LAT = 1,
   localparam int SEL_W    = sel_w(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]  id_src,
   input  logic [NUM_SRC-1:0]         id_src_used,
   input  logic [REG_AW-1:0]          id_dst,
   input  logic                       id_wen,
   input  logic                       id_is_load,
   input  logic                       flush,
   input  logic                       freeze,
   input  logic                       stat_clr,
   output logic                       stall,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_ex,
   output logic [15:0]                stall_cnt
);

   tag_entry_t                 e [DEPTH];
   logic [NUM_SRC*SEL_W-1:0]   sel_c;
   logic [NUM_SRC-1:0]         load_hit;
   logic                       trackable;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_match #(
         .REG_AW   (REG_AW),
         .DEPTH    (DEPTH),
         .LOAD_LAT (LOAD_LAT),
         .SEL_W    (SEL_W)
      ) u_match (
         .tags     (e),
         .src      (id_src[i*REG_AW +: REG_AW]),
         .used     (id_src_used[i]),
         .sel      (sel_c[i*SEL_W +: SEL_W]),
         .load_hit (load_hit[i])
      );
   end

   // Register 0 is hardwired, so writes to it are never tracked.
   assign trackable = id_valid && id_wen && (id_dst != '0);
   assign stall     = id_valid && (|load_hit) && !flush;

   // Tag pipeline and forwarding select register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            e[k] <= '0;
         end
         fwd_sel_ex <= '0;
      end else if (!freeze) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            e[k] <= e[k-1];
         end
         if (flush || stall) begin
            e[0]       <= '0;
            fwd_sel_ex <= '0;
         end else begin
            e[0]       <= '{valid: trackable, dst: TAG_AW'(id_dst), is_load: id_is_load};
            fwd_sel_ex <= sel_c;
         end
      end
   end

   // Load-use stall statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (!freeze) begin
         if (stat_clr) begin
            stall_cnt <= '0;
         end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit with default parameters.
module tb_fwd_hazard_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [9:0]  id_src;
   logic [1:0]  id_src_used;
   logic [4:0]  id_dst;
   logic        id_wen;
   logic        id_is_load;
   logic        flush;
   logic        freeze;
   logic        stat_clr;
   logic        stall;
   logic [3:0]  fwd_sel_ex;
   logic [15:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_src      (id_src),
      .id_src_used (id_src_used),
      .id_dst      (id_dst),
      .id_wen      (id_wen),
      .id_is_load  (id_is_load),
      .flush       (flush),
      .freeze      (freeze),
      .stat_clr    (stat_clr),
      .stall       (stall),
      .fwd_sel_ex  (fwd_sel_ex),
      .stall_cnt   (stall_cnt)
   );

   typedef struct {
      logic        v;
      logic [4:0]  s0;
      logic [4:0]  s1;
      logic [1:0]  used;
      logic [4:0]  dst;
      logic        wen;
      logic        ld;
      logic        fl;
      logic        fz;
      logic        clr;
      logic        exp_stall;
      logic [1:0]  exp_sel0;
      logic [1:0]  exp_sel1;
      logic [15:0] exp_cnt;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                               input logic [1:0] used, input logic [4:0] dst, input logic wen,
                               input logic ld, input logic fl, input logic fz, input logic clr,
                               input logic st, input logic [1:0] e0, input logic [1:0] e1,
                               input logic [15:0] cnt);
      vec_t r;
      r.v = v; r.s0 = s0; r.s1 = s1; r.used = used; r.dst = dst; r.wen = wen; r.ld = ld;
      r.fl = fl; r.fz = fz; r.clr = clr; r.exp_stall = st; r.exp_sel0 = e0; r.exp_sel1 = e1;
      r.exp_cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] dst, input logic wen,
                        input logic ld, input logic fl, input logic fz, input logic clr);
      id_valid = v; id_src = {s1, s0}; id_src_used = used; id_dst = dst; id_wen = wen;
      id_is_load = ld; flush = fl; freeze = fz; stat_clr = clr;
   endtask

   // One load followed by a self-dependent consumer: one stall cycle, then it advances.
   task automatic load_use_pair(input string tag);
      @(negedge clk);
      drive(1, 0, 0, 2'b00, 12, 1, 1, 0, 0, 0);
      @(negedge clk);
      drive(1, 12, 0, 2'b01, 0, 0, 0, 0, 0, 0);
      #1 chk({tag, " stall"}, 32'(stall), 32'd1);
      @(negedge clk);
      #1 chk({tag, " release"}, 32'(stall), 32'd0);
   endtask

   initial begin
      //            v  s0 s1 used  dst wen ld fl fz clr  st sel0 sel1 cnt
      vecs[0]  = mk(1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0);   // add r3,r1,r2
      vecs[1]  = mk(1, 3, 3, 2'b11, 4, 1, 0, 0, 0, 0,  0, 1, 1, 0);   // sub r4,r3,r3
      vecs[2]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // nop
      vecs[3]  = mk(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0);   // add r3
      vecs[4]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // nop
      vecs[5]  = mk(1, 3, 1, 2'b11, 5, 1, 0, 0, 0, 0,  0, 2, 0, 0);   // or r5,r3,r1
      vecs[6]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
      vecs[7]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
      vecs[8]  = mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0);   // r5 three ahead
      vecs[9]  = mk(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // r5 out of range
      vecs[10] = mk(1, 0, 0, 2'b00, 6, 1, 1, 0, 0, 0,  0, 0, 0, 0);   // lw r6
      vecs[11] = mk(1, 6, 2, 2'b11, 7, 1, 0, 0, 0, 0,  1, 0, 0, 1);   // add r7,r6,r2 stalls
      vecs[12] = mk(1, 6, 2, 2'b11, 7, 1, 0, 0, 0, 0,  0, 2, 0, 1);
      vecs[13] = mk(1, 0, 0, 2'b00, 6, 1, 1, 0, 0, 0,  0, 0, 0, 1);   // lw r6
      vecs[14] = mk(1, 0, 0, 2'b00, 6, 1, 0, 0, 0, 0,  0, 0, 0, 1);   // add r6 shadows it
      vecs[15] = mk(1, 6, 6, 2'b11, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1);
      vecs[16] = mk(1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1);   // lw r0
      vecs[17] = mk(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);   // use r0,r0
      vecs[18] = mk(1, 0, 0, 2'b00, 8, 1, 1, 0, 0, 0,  0, 0, 0, 1);   // lw r8
      vecs[19] = mk(1, 8, 0, 2'b01, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1);   // use r8 with flush
      vecs[20] = mk(1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1);
      vecs[21] = mk(1, 8, 0, 2'b01, 9, 1, 1, 0, 0, 0,  0, 3, 0, 1);   // lw r9,(r8)
      vecs[22] = mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 0,  1, 3, 0, 1);   // frozen stall
      vecs[23] = mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 1,  1, 3, 0, 1);   // clear ignored
      vecs[24] = mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 0,  1, 3, 0, 1);
      vecs[25] = mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2);   // resume
      vecs[26] = mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0,  0, 2, 0, 2);
      vecs[27] = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0);   // stat_clr
      vecs[28] = mk(1, 0, 0, 2'b00, 13, 1, 1, 0, 0, 0, 0, 0, 0, 0);   // lw r13
      vecs[29] = mk(1, 0, 13, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);   // operand 1 hazard
      vecs[30] = mk(1, 0, 13, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);

      rst_n = 1'b0;
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset stall", 32'(stall), 32'd0);
      chk("reset fwd_sel_ex", 32'(fwd_sel_ex), 32'd0);
      chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].s0, vecs[i].s1, vecs[i].used, vecs[i].dst, vecs[i].wen,
               vecs[i].ld, vecs[i].fl, vecs[i].fz, vecs[i].clr);
         #1 chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].exp_stall));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d sel0", i), 32'(fwd_sel_ex[1:0]), 32'(vecs[i].exp_sel0));
         chk($sformatf("vec%0d sel1", i), 32'(fwd_sel_ex[3:2]), 32'(vecs[i].exp_sel1));
         chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_cnt));
      end

      // Counter saturation, starting just below the ceiling.
      @(negedge clk);
      drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      force dut.stall_cnt = 16'hFFFD;
      #1 release dut.stall_cnt;
      load_use_pair("sat1");
      chk("sat1 stall_cnt", 32'(stall_cnt), 32'h0000FFFE);
      load_use_pair("sat2");
      chk("sat2 stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
      load_use_pair("sat3");
      chk("sat3 stall_cnt", 32'(stall_cnt), 32'h0000FFFF);

      // Asynchronous reset in the middle of a load-use stall.
      @(negedge clk);
      drive(1, 0, 0, 2'b00, 11, 1, 0, 0, 0, 0);
      @(negedge clk);
      drive(1, 11, 0, 2'b01, 10, 1, 1, 0, 0, 0);
      @(negedge clk);
      chk("pre-reset sel0", 32'(fwd_sel_ex[1:0]), 32'd1);
      drive(1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 0);
      #1 chk("pre-reset stall", 32'(stall), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid reset stall", 32'(stall), 32'd0);
      chk("mid reset fwd_sel_ex", 32'(fwd_sel_ex), 32'd0);
      chk("mid reset stall_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post reset stall", 32'(stall), 32'd0);
      chk("post reset stall_cnt", 32'(stall_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
